// File: rtl/timer_pkg.sv
// Shared types and constants for the seconds countdown engine.
package timer_pkg;

  localparam int SEC_W       = 8;
  localparam int DEF_MAX_SEC = 239;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic [SEC_W-1:0] clamp_sec(input logic [SEC_W-1:0] val,
                                                 input logic [SEC_W-1:0] max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler counting 0..CLK_HZ-1 while enabled; tick_o marks the terminal count.
module tick_gen #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int            PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] TC = PW'(CLK_HZ - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == TC) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Combinational so the decrement lands on the same edge the prescaler wraps.
  assign tick_o = en_i && (cnt_q == TC);

endmodule

// File: rtl/countdown_timer.sv
// Seconds countdown engine (IDLE/RUN/PAUSE/DONE) feeding the mm:ss digit decoder.
// Define COUNTDOWN_EDGE_EN to treat load/start_stop/clear as levels with internal edge detect.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int MAX_SEC = DEF_MAX_SEC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [SEC_W-1:0] load_val,
  input  logic             start_stop,
  input  logic             clear,
  output logic [SEC_W-1:0] num,
  output logic             running,
  output logic             done
);

  localparam logic [SEC_W-1:0] MAX_NUM = SEC_W'(MAX_SEC);

  state_e           state_q, state_d;
  logic [SEC_W-1:0] num_q, num_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
  logic             clr_req, load_req, ss_req;
  logic             pre_clr, run_en, tick;

`ifdef COUNTDOWN_EDGE_EN
  logic [2:0] lvl_q, prev_q, arm_q;

  // arm_q only sets once an input is seen low, so a level held through reset is not a request.
  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_q  <= '0;
      prev_q <= '0;
      arm_q  <= '0;
    end else begin
      lvl_q  <= {clear, load, start_stop};
      prev_q <= lvl_q;
      arm_q  <= arm_q | ~{clear, load, start_stop};
    end
  end

  assign {clr_req, load_req, ss_req} = lvl_q & ~prev_q & arm_q;
`else
  assign {clr_req, load_req, ss_req} = {clear, load, start_stop};
`endif

  assign run_en = (state_q == RUN);

  tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .en_i  (run_en),
    .clr_i (pre_clr),
    .tick_o(tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      num_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    pre_clr = 1'b0;
    if (clr_req) begin
      state_d = IDLE;
      num_d   = '0;
      pre_clr = 1'b1;
    end else if (load_req && (state_q != RUN)) begin
      state_d = IDLE;
      num_d   = clamp_sec(load_val, MAX_NUM);
      pre_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (ss_req && (num_q != '0)) begin
            state_d = RUN;
            pre_clr = 1'b1;
          end
        end
        RUN: begin
          // A load in RUN is ignored but still outranks start_stop in the same cycle.
          if (ss_req && !load_req) begin
            state_d = PAUSE;
          end
          if (tick && (num_q != '0)) begin
            num_d = num_q - 1'b1;
            if (num_q == 8'd1) begin
              state_d = DONE;
            end
          end
        end
        PAUSE: begin
          if (ss_req) begin
            state_d = RUN;
          end
        end
        DONE: begin
          num_d = '0;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    running_d = (state_d == RUN);
    done_d    = (state_d == DONE);
  end

  assign num     = num_q;
  assign running = running_q;
  assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer at CLK_HZ=4: stimulus queues cycle-stamped expectations, a monitor checks them.
module tb_countdown_timer;

`ifdef COUNTDOWN_EDGE_EN
  localparam int L = 1;
`else
  localparam int L = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'd0;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] num;
  logic       running;
  logic       done;

  countdown_timer #(
    .CLK_HZ (4),
    .MAX_SEC(239)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_val  (load_val),
    .start_stop(start_stop),
    .clear     (clear),
    .num       (num),
    .running   (running),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [7:0] n;
    logic       r;
    logic       d;
    string      name;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].c < cyc) begin
      mon_e = q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL %s: cycle %0d passed unchecked, now at cycle %0d", mon_e.name, mon_e.c, cyc);
    end
    while (q.size() > 0 && q[0].c == cyc) begin
      mon_e = q.pop_front();
      vectors++;
      if (num !== mon_e.n || running !== mon_e.r || done !== mon_e.d) begin
        miscompares++;
        $display("FAIL %s @%0d: got num=%0d running=%0b done=%0b, expected num=%0d running=%0b done=%0b",
                 mon_e.name, cyc, num, running, done, mon_e.n, mon_e.r, mon_e.d);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input int c, input logic [7:0] n, input logic r, input logic d,
                          input string nm);
    exp_t e;
    e.c = c; e.n = n; e.r = r; e.d = d; e.name = nm;
    q.push_back(e);
  endtask

  // One-cycle request followed by one low cycle, so back-to-back requests stay distinct edges.
  task automatic pulse(input logic ld, input logic [7:0] v, input logic ss, input logic cl);
    load = ld; load_val = v; start_stop = ss; clear = cl;
    step();
    load = 1'b0; start_stop = 1'b0; clear = 1'b0;
    step();
  endtask

  task automatic wait_cyc(input int t);
    int g;
    g = 0;
    if (cyc > t) begin
      $display("FAIL sched: at cycle %0d, required at most %0d", cyc, t);
      $fatal(1, "schedule overrun");
    end
    while (cyc < t && g < 5000) begin
      step();
      g++;
    end
  endtask

  initial begin
    int t, e0, p, r, a, s, g;
    step();
    step();
    rst = 1'b0;
    expect_v(cyc, 8'd0, 1'b0, 1'b0, "reset");
    step();

    // Load 5 and count down to expiry.
    t = cyc;
    expect_v(t + 1 + L, 8'd5, 1'b0, 1'b0, "load5");
    pulse(1'b1, 8'd5, 1'b0, 1'b0);
    t = cyc;
    e0 = t + 1 + L;
    expect_v(e0, 8'd5, 1'b1, 1'b0, "start5");
    for (int k = 1; k <= 5; k++) begin
      expect_v(e0 + 4 * k - 1, 8'(6 - k), 1'b1, 1'b0, "pre_dec");
      expect_v(e0 + 4 * k, 8'(5 - k), (k < 5), (k == 5), "dec");
    end
    expect_v(e0 + 30, 8'd0, 1'b0, 1'b1, "done_hold");
    pulse(1'b0, 8'd0, 1'b1, 1'b0);
    wait_cyc(e0 + 30);

    // Clamp, then a start with zero count is ignored.
    t = cyc;
    expect_v(t + 1 + L, 8'd239, 1'b0, 1'b0, "clamp250");
    pulse(1'b1, 8'd250, 1'b0, 1'b0);
    t = cyc;
    expect_v(t + 1 + L, 8'd0, 1'b0, 1'b0, "load0");
    pulse(1'b1, 8'd0, 1'b0, 1'b0);
    t = cyc;
    expect_v(t + 1 + L, 8'd0, 1'b0, 1'b0, "start_at0");
    expect_v(t + 6 + L, 8'd0, 1'b0, 1'b0, "idle_hold0");
    pulse(1'b0, 8'd0, 1'b1, 1'b0);
    wait_cyc(t + 6 + L);

    // Pause two cycles into a second, resume, finish the partial second.
    t = cyc;
    expect_v(t + 1 + L, 8'd3, 1'b0, 1'b0, "load3");
    pulse(1'b1, 8'd3, 1'b0, 1'b0);
    t = cyc;
    e0 = t + 1 + L;
    p = e0 + 2;
    r = p + 10;
    expect_v(e0, 8'd3, 1'b1, 1'b0, "run3");
    expect_v(p, 8'd3, 1'b0, 1'b0, "paused");
    expect_v(p + 5, 8'd3, 1'b0, 1'b0, "pause_hold");
    expect_v(r, 8'd3, 1'b1, 1'b0, "resumed");
    expect_v(r + 1, 8'd3, 1'b1, 1'b0, "resume_partial");
    expect_v(r + 2, 8'd2, 1'b1, 1'b0, "dec_after_resume");
    expect_v(r + 6, 8'd1, 1'b1, 1'b0, "dec_full_sec");
    expect_v(r + 10, 8'd0, 1'b0, 1'b1, "done3");
    pulse(1'b0, 8'd0, 1'b1, 1'b0);
    wait_cyc(p - 1 - L);
    pulse(1'b0, 8'd0, 1'b1, 1'b0);
    wait_cyc(r - 1 - L);
    pulse(1'b0, 8'd0, 1'b1, 1'b0);
    wait_cyc(r + 10);

    // Load ignored in RUN, then clear beats load and start_stop.
    t = cyc;
    expect_v(t + 1 + L, 8'd9, 1'b0, 1'b0, "load9");
    pulse(1'b1, 8'd9, 1'b0, 1'b0);
    t = cyc;
    e0 = t + 1 + L;
    a = e0 + 10 + L;
    expect_v(e0, 8'd9, 1'b1, 1'b0, "run9");
    expect_v(e0 + 4, 8'd8, 1'b1, 1'b0, "dec9");
    expect_v(e0 + 8, 8'd7, 1'b1, 1'b0, "load_in_run_ignored");
    expect_v(a, 8'd0, 1'b0, 1'b0, "clear_priority");
    expect_v(a + 5, 8'd0, 1'b0, 1'b0, "clear_hold");
    pulse(1'b0, 8'd0, 1'b1, 1'b0);
    wait_cyc(e0 + 4);
    pulse(1'b1, 8'd2, 1'b0, 1'b0);
    wait_cyc(e0 + 9);
    pulse(1'b1, 8'd9, 1'b1, 1'b1);
    wait_cyc(a + 5);

    // Reset in the middle of a run.
    t = cyc;
    expect_v(t + 1 + L, 8'd4, 1'b0, 1'b0, "load4");
    pulse(1'b1, 8'd4, 1'b0, 1'b0);
    t = cyc;
    e0 = t + 1 + L;
    expect_v(e0, 8'd4, 1'b1, 1'b0, "run4");
    expect_v(e0 + 4, 8'd3, 1'b1, 1'b0, "dec4");
    pulse(1'b0, 8'd0, 1'b1, 1'b0);
    wait_cyc(e0 + 5);
    expect_v(e0 + 6, 8'd0, 1'b0, 1'b0, "rst_mid_run");
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    t = cyc;
    expect_v(t + 1 + L, 8'd0, 1'b0, 1'b0, "start_after_rst");
    expect_v(t + 4 + L, 8'd0, 1'b0, 1'b0, "idle_after_rst");
    pulse(1'b0, 8'd0, 1'b1, 1'b0);
    wait_cyc(t + 4 + L);

`ifdef COUNTDOWN_EDGE_EN
    // Held start_stop yields a single start.
    t = cyc;
    expect_v(t + 2, 8'd8, 1'b0, 1'b0, "load8");
    pulse(1'b1, 8'd8, 1'b0, 1'b0);
    s = cyc;
    expect_v(s + 2, 8'd8, 1'b1, 1'b0, "edge_start");
    expect_v(s + 6, 8'd7, 1'b1, 1'b0, "edge_dec1");
    expect_v(s + 10, 8'd6, 1'b1, 1'b0, "edge_dec2");
    expect_v(s + 14, 8'd5, 1'b1, 1'b0, "edge_dec3");
    expect_v(s + 18, 8'd4, 1'b1, 1'b0, "edge_dec4");
    expect_v(s + 22, 8'd3, 1'b1, 1'b0, "edge_no_toggle");
    start_stop = 1'b1;
    repeat (20) step();
    start_stop = 1'b0;
    wait_cyc(s + 22);
`endif

    g = 0;
    while (q.size() > 0 && g < 100) begin
      step();
      g++;
    end
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Seconds countdown engine that produces the 8-bit seconds value (0–239, i.e. up to 3:59) consumed by the minutes/seconds digit decoder feeding the 7-segment display. It holds a loadable count, decrements it once per second from a prescaled system clock under start/pause control, and flags expiry. It sits directly upstream of the decoder; `num` connects straight to the decoder's `num` input.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency; one tick every CLK_HZ cycles (min 2)
- `MAX_SEC`, 239, largest loadable count; loads above it clamp to it
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `load`  in  1  load request (pulse); captures `load_val`
- `load_val`  in  8  seconds value to load
- `start_stop`  in  1  start/pause toggle request (pulse)
- `clear`  in  1  abort request (pulse); returns to IDLE with count 0
- `num`  out  8  current remaining seconds, registered
- `running`  out  1  high while in RUN
- `done`  out  1  high while in DONE (count expired)

## Operation
- States: IDLE, RUN, PAUSE, DONE. Reset: state IDLE, `num`=0, prescaler=0, `running`=0, `done`=0.
- Request priority in one cycle: `clear` > `load` > `start_stop`; lower-priority requests in the same cycle are dropped.
- `clear`: any state -> IDLE, `num`=0, prescaler=0.
- `load`: accepted in IDLE, PAUSE, DONE -> IDLE, `num` = min(`load_val`, MAX_SEC), prescaler=0. Ignored in RUN.
- `start_stop`: IDLE -> RUN if `num`≠0 (prescaler cleared); ignored if `num`=0. RUN -> PAUSE. PAUSE -> RUN (prescaler resumes from held value). Ignored in DONE.
- RUN: prescaler counts 0..CLK_HZ-1; on terminal count it wraps to 0 and issues a tick. On tick, `num` decrements by 1; if the new value is 0, state -> DONE in the same edge.
- PAUSE: prescaler and `num` hold.
- DONE: `num`=0, holds until `clear` or `load`.
- `num` never wraps below 0 and never exceeds MAX_SEC. Prescaler width $clog2(CLK_HZ); `num` arithmetic unsigned 8-bit.

## Timing
- All outputs registered; requests take effect on the edge where sampled, visible next cycle.
- From `start_stop` accepted at edge E0 (IDLE->RUN), first decrement at edge E0+CLK_HZ, subsequent every CLK_HZ cycles of RUN time.
- Pause/resume preserves partial second: total RUN cycles between decrements is exactly CLK_HZ.
- `done` and `num`=0 become visible in the same cycle; `running` falls in that same cycle.
- `rst` mid-operation overrides everything, reset values next cycle.

## Configuration
- `COUNTDOWN_EDGE_EN` defined: `load`, `start_stop`, `clear` are treated as debounced levels; one register stage plus rising-edge detect internal, so a held button yields one request; adds one cycle of request latency. Edge registers reset to 0 (a level high out of reset is not a request until it falls and rises).
- Not defined: inputs are already single-cycle pulses, used directly; holding `start_stop` high toggles every cycle.

## Structure
- Shared package `timer_pkg`: state enum (IDLE, RUN, PAUSE, DONE), `SEC_W`=8, default `MAX_SEC`=239.
- One sub-module: `tick_gen` (prescaler with enable and synchronous clear, outputs one-cycle `tick`).
- Edge detection under the macro stays inline in the top.

## Test plan
(CLK_HZ=4 for all)
- Reset: hold `rst` 2 cycles -> `num`=0, `running`=0, `done`=0, state IDLE.
- Load 5, start -> `num` steps 5,4,3,2,1,0 at 4-cycle intervals starting 4 cycles after start; `done`=1 and `running`=0 with `num`=0.
- Load 250 -> `num`=239; load 0 then `start_stop` -> stays IDLE, `running`=0.
- Load 3, start, pause after 2 cycles for 10 cycles, resume -> first decrement 2 cycles after resume; `num` holds 3 during pause.
- Same-cycle `clear`+`load`(9)+`start_stop` during RUN -> IDLE, `num`=0; `load` during RUN -> ignored, count continues.
- With `COUNTDOWN_EDGE_EN`: hold `start_stop` high 20 cycles after load 8 -> single start, no toggling; `running`=1 two cycles after rise.
